booth_mul_pipe: RTL and testbench
=================================

# booth_mul_pipe

Parametrised, pipelined radix-4 Booth / Wallace-tree multiplier with a valid/ready handshake, per-operand signedness, an in-order tag, and a pipeline flush. It is the next-generation multiply unit for the CPU execute stage. It generalises the fixed 32-bit, fixed-latency multiplier to any even operand width and a selectable pipeline depth, and adds back-pressure, kill and MULHSU-style mixed-sign support.

## Interface
- WIDTH, 32, operand width in bits; even, 8..64
- STAGES, 2, pipeline depth; 2 or 3
- TAG_W, 4, width of the pass-through tag
- mul_clk  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- flush  input  1  kills every in-flight and held operation
- in_valid  input  1  operand set present
- in_ready  output  1  unit can accept this cycle
- x  input  WIDTH  multiplicand
- y  input  WIDTH  multiplier
- x_signed  input  1  x is two's complement
- y_signed  input  1  y is two's complement
- in_tag  input  TAG_W  opaque tag (e.g. destination register)
- out_valid  output  1  result present
- out_ready  input  1  consumer takes the result this cycle
- result  output  2*WIDTH  exact product; the consumer splits it into HI and LO
- out_tag  output  TAG_W  tag of the result

## Operation
- Accept happens when in_valid & in_ready.
- Operands are extended to WIDTH+2 bits: sign-extended if their signed bit is set, zero-extended otherwise.
- Booth recoding uses {y_ext, 1'b0} and produces WIDTH/2+1 partial products.
  - Negative selections (100, 101, 110) use inverted bits plus a +1 injected into the compression tree. No separate negation adder is used.
  - 011 and 100 select 2×; 000 and 111 select 0.
- Partial products and +1 bits are reduced per column by a carry-save tree to a sum vector and a carry vector. A carry-propagate adder then produces the product. The product is the low 2*WIDTH bits, and it is exact for all four signedness combinations.
- Pipeline registers per STAGES:
  - STAGES=2: register S1 after the tree (sum/carry); register S2 after the final add. S2 drives the outputs.
  - STAGES=3: register S1 after Booth decode (partial products and +1 bits); register S2 after the tree; register S3 after the final add.
- Each stage carries a valid bit and the tag alongside its data.
- Global stall: stall = out_valid & ~out_ready. While stall is high, every stage holds, and result and out_tag stay stable.
- in_ready = ~stall & ~flush & ~reset.
- Bubbles are not collapsed.
- Results leave in acceptance order.
- flush clears every stage valid bit, including the output stage, on that edge. The data registers may keep stale values. An input presented in a flush cycle is not accepted.

## Timing
- Reset (synchronous): all valid bits 0, result 0, out_tag 0, in_ready 0 during the reset cycle. in_ready is 1 from the first cycle after reset deasserts.
- Latency: an operand accepted at edge N appears with out_valid=1 after edge N+STAGES-1. For example, with STAGES=2 it is visible in the cycle following the accept edge plus one.
- Throughput is one result per cycle when out_ready stays high.
- Output transfer happens when out_valid & out_ready. On the same edge the pipeline advances, and a new accept may occur in that cycle.
- Once out_valid is high, it stays high with result and out_tag unchanged until the transfer, a flush or a reset.
- Flush and out_ready both high in the same cycle: the output transfer is still counted as taken by the consumer, and the valid bits clear.
- Reset has priority over flush. Flush has priority over accept.
- Reset or flush mid-operation: no partial or stale result is ever presented with out_valid=1 afterwards.

## Test plan
- Back-to-back, WIDTH=32, STAGES=2, signed -1×-1 then unsigned 0xFFFFFFFF×0xFFFFFFFF, out_ready=1 -> results 0x0000000000000001 then 0xFFFFFFFE00000001 on consecutive cycles, with tags in order.
- Mixed sign: x=0xFFFFFFFF with x_signed=1, y=0xFFFFFFFF with y_signed=0 -> 0xFFFFFFFF00000001. Signed 0x80000000×0x80000000 -> 0x4000000000000000.
- Back-pressure: stream 5 ops with out_ready=0 for 4 cycles -> in_ready drops once the output holds, result is stable during the stall, and all 5 results arrive in order with none lost or duplicated.
- Flush with 2 ops in flight and one presented in the same cycle -> no out_valid for any of the three. The next op after flush returns correctly at nominal latency.
- Reset asserted mid-stream -> out_valid=0 and result=0 the next cycle. in_ready=1 one cycle after reset releases.
- Random sweep of WIDTH ∈ {8, 16, 32, 64} × STAGES ∈ {2, 3}, 10k ops each with random signedness and out_ready -> every result matches a behavioural 2*WIDTH-bit product.

Source files
------------

// File: rtl/booth_mul_pipe_if.sv
// rtl/booth_mul_pipe_if.sv - operand/result handshake bundle for booth_mul_pipe
//
// Purpose: groups the producer-side operand channel and the consumer-side
// result channel of the pipelined multiplier.
// Signals:
//   in_valid/in_ready   operand handshake
//   x, y                multiplicand / multiplier (WIDTH bits)
//   x_signed, y_signed  per-operand two's complement select
//   in_tag / out_tag    opaque tag travelling with the operation
//   out_valid/out_ready result handshake
//   result              full 2*WIDTH-bit product
// Modports: master = operand producer and result consumer, slave = multiplier.
`timescale 1ns/1ps

interface booth_mul_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   x;
  logic [WIDTH-1:0]   y;
  logic               x_signed;
  logic               y_signed;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] result;
  logic [TAG_W-1:0]   out_tag;

  modport master (
    output in_valid, x, y, x_signed, y_signed, in_tag, out_ready,
    input  in_ready, out_valid, result, out_tag
  );

  modport slave (
    input  in_valid, x, y, x_signed, y_signed, in_tag, out_ready,
    output in_ready, out_valid, result, out_tag
  );
endinterface

// File: rtl/booth_mul_pipe.sv
// rtl/booth_mul_pipe.sv - pipelined radix-4 Booth / Wallace-tree multiplier
//
// Purpose: exact 2*WIDTH-bit product of two WIDTH-bit operands, each
// independently signed or unsigned, with valid/ready flow control, an
// in-order pass-through tag and a flush that kills all in-flight work.
// Parameters: WIDTH (even, 8..64), STAGES (2 or 3), TAG_W.
// Ports:
//   mul_clk  clock, rising edge
//   reset    synchronous active-high reset
//   flush    clears every stage valid bit; an input offered this cycle is dropped
//   bus      booth_mul_pipe_if.slave operand/result handshake
// Pipeline: STAGES=2 -> [decode+tree] | [final add] | out
//           STAGES=3 -> [decode] | [tree] | [final add] | out
`timescale 1ns/1ps

module booth_mul_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input logic             mul_clk,
  input logic             reset,
  input logic             flush,
  booth_mul_pipe_if.slave bus
);
  localparam int PW   = 2 * WIDTH;    // product width
  localparam int NPP  = WIDTH / 2 + 1;  // Booth partial products
  localparam int ROWS = NPP + 1;        // plus one row holding the +1 bits

  logic              stall;
  logic              adv;
  logic              accept;
  logic [STAGES-1:0] vld;
  logic [TAG_W-1:0]  tag_q [STAGES];
  logic [PW-1:0]     res_q;

  logic [PW-1:0]     dec_rows [ROWS];
  logic [PW-1:0]     tree_in  [ROWS];
  logic [PW-1:0]     tree_sum;
  logic [PW-1:0]     tree_carry;
  logic [PW-1:0]     fin_sum;
  logic [PW-1:0]     fin_carry;

  // A held output freezes the whole pipe; bubbles are never squeezed out.
  assign stall        = vld[STAGES-1] & ~bus.out_ready;
  assign adv          = ~stall;
  assign bus.in_ready = ~stall & ~flush & ~reset;
  assign accept       = bus.in_valid & bus.in_ready;

  // Booth decode. Operands are widened by two bits so the unsigned case
  // looks like a positive signed number; every row is sign-extended to the
  // full product width, so the modulo-2^PW sum is the exact product.
  // Negative selections are emitted as one's complement; the missing +1 of
  // row i lands at bit 2*i of the extra row.
  always_comb begin : booth_decode
    logic [WIDTH+1:0] x_ext;
    logic [WIDTH+1:0] y_ext;
    logic [WIDTH+2:0] y_win;
    logic [PW-1:0]    x_full;
    logic [PW-1:0]    mag;
    logic [2:0]       sel;
    logic             neg;
    x_ext  = {{2{bus.x_signed & bus.x[WIDTH-1]}}, bus.x};
    y_ext  = {{2{bus.y_signed & bus.y[WIDTH-1]}}, bus.y};
    y_win  = {y_ext, 1'b0};
    x_full = {{(PW-WIDTH-2){x_ext[WIDTH+1]}}, x_ext};
    mag    = '0;
    sel    = '0;
    neg    = 1'b0;
    dec_rows[ROWS-1] = '0;
    for (int i = 0; i < NPP; i++) begin
      sel = y_win[2*i +: 3];
      case (sel)
        3'b001, 3'b010, 3'b101, 3'b110: mag = x_full;
        3'b011, 3'b100:                 mag = x_full << 1;
        default:                        mag = '0;
      endcase
      neg = sel[2] & ~(sel[1] & sel[0]);
      dec_rows[i] = (neg ? ~mag : mag) << (2 * i);
      dec_rows[ROWS-1][2*i] = neg;
    end
  end

  // Wallace reduction: each level turns every complete group of three rows
  // into a sum row and a shifted majority row; leftovers pass through.
  // The arrays carry two spare entries so the triple reads stay in range.
  always_comb begin : csa_tree
    logic [PW-1:0] lvl [ROWS+2];
    logic [PW-1:0] nxt [ROWS+2];
    int            n;
    int            k;
    lvl = '{default: '0};
    nxt = '{default: '0};
    for (int i = 0; i < ROWS; i++) lvl[i] = tree_in[i];
    n = ROWS;
    k = 0;
    for (int l = 0; l < ROWS; l++) begin
      if (n > 2) begin
        nxt = '{default: '0};
        k   = 0;
        for (int j = 0; j < ROWS; j += 3) begin
          if (j + 2 < n) begin
            nxt[k]   = lvl[j] ^ lvl[j+1] ^ lvl[j+2];
            nxt[k+1] = ((lvl[j] & lvl[j+1]) | (lvl[j] & lvl[j+2]) |
                        (lvl[j+1] & lvl[j+2])) << 1;
            k = k + 2;
          end else begin
            if (j < n) begin
              nxt[k] = lvl[j];
              k = k + 1;
            end
            if (j + 1 < n) begin
              nxt[k] = lvl[j+1];
              k = k + 1;
            end
          end
        end
        lvl = nxt;
        n   = k;
      end
    end
    tree_sum   = lvl[0];
    tree_carry = lvl[1];
  end

  if (STAGES == 2) begin : g_s2
    logic [PW-1:0] s1_sum;
    logic [PW-1:0] s1_carry;

    assign tree_in   = dec_rows;
    assign fin_sum   = s1_sum;
    assign fin_carry = s1_carry;

    always_ff @(posedge mul_clk) begin
      if (adv) begin
        s1_sum   <= tree_sum;
        s1_carry <= tree_carry;
      end
    end
  end else begin : g_s3
    logic [PW-1:0] s1_rows [ROWS];
    logic [PW-1:0] s2_sum;
    logic [PW-1:0] s2_carry;

    assign tree_in   = s1_rows;
    assign fin_sum   = s2_sum;
    assign fin_carry = s2_carry;

    always_ff @(posedge mul_clk) begin
      if (adv) begin
        s1_rows  <= dec_rows;
        s2_sum   <= tree_sum;
        s2_carry <= tree_carry;
      end
    end
  end

  // Output data register: cleared only by reset; after a flush it may hold
  // a stale value but its valid bit is already low.
  always_ff @(posedge mul_clk) begin
    if (reset) begin
      res_q <= '0;
    end else if (adv) begin
      res_q <= fin_sum + fin_carry;
    end
  end

  // Valid and tag shift together with the data; flush beats advance.
  always_ff @(posedge mul_clk) begin
    if (reset) begin
      vld <= '0;
      for (int i = 0; i < STAGES; i++) tag_q[i] <= '0;
    end else begin
      if (adv) begin
        tag_q[0] <= bus.in_tag;
        for (int i = 1; i < STAGES; i++) tag_q[i] <= tag_q[i-1];
      end
      if (flush) begin
        vld <= '0;
      end else if (adv) begin
        vld <= {vld[STAGES-2:0], accept};
      end
    end
  end

  assign bus.out_valid = vld[STAGES-1];
  assign bus.result    = res_q;
  assign bus.out_tag   = tag_q[STAGES-1];
endmodule

// File: tb/tb_booth_mul_pipe.sv
// tb/tb_booth_mul_pipe.sv - self-checking bench for booth_mul_pipe
`timescale 1ns/1ps

module tb_booth_mul_pipe;
  localparam int NOPS = 10000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: two's-complement extend each operand to 130 bits, multiply,
  // keep the low 2*w bits.
  function automatic logic [127:0] ref_any(input int w, input logic [63:0] a, input logic [63:0] b,
                                           input logic as, input logic bs);
    logic [129:0] ea, eb, mask, p;
    mask = ~((130'd1 << w) - 130'd1);
    ea = {66'd0, a};
    eb = {66'd0, b};
    if (as && a[w-1]) ea = ea | mask;
    if (bs && b[w-1]) eb = eb | mask;
    p = ea * eb;
    return p[127:0] & ((128'd1 << (2 * w)) - 128'd1);
  endfunction

  // ---------------- directed DUT: WIDTH=32, STAGES=2 ----------------
  logic m_reset;
  logic m_flush;
  booth_mul_pipe_if #(.WIDTH(32), .TAG_W(4)) mb ();
  booth_mul_pipe #(.WIDTH(32), .STAGES(2), .TAG_W(4)) dut (
    .mul_clk(clk), .reset(m_reset), .flush(m_flush), .bus(mb)
  );

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        xs;
    logic        ys;
    logic [63:0] exp;
  } vec_t;

  vec_t vt [12];

  task automatic m_idle();
    mb.in_valid = 1'b0;
    mb.x        = '0;
    mb.y        = '0;
    mb.x_signed = 1'b0;
    mb.y_signed = 1'b0;
    mb.in_tag   = '0;
  endtask

  task automatic m_op(input logic [31:0] a, input logic [31:0] b, input logic as, input logic bs,
                      input logic [3:0] tg);
    mb.in_valid = 1'b1;
    mb.x        = a;
    mb.y        = b;
    mb.x_signed = as;
    mb.y_signed = bs;
    mb.in_tag   = tg;
  endtask

  // One isolated operation with an exact latency check.
  task automatic single_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                           input logic as, input logic bs, input logic [3:0] tg,
                           input logic [63:0] exp);
    @(negedge clk);
    m_op(a, b, as, bs, tg);
    mb.out_ready = 1'b1;
    #1 check({nm, "_rdy"}, mb.in_ready, 1);
    @(negedge clk);
    m_idle();
    check({nm, "_early"}, mb.out_valid, 0);
    @(negedge clk);
    check({nm, "_vld"}, mb.out_valid, 1);
    check(nm, mb.result, exp);
    check({nm, "_tag"}, mb.out_tag, tg);
    @(negedge clk);
    check({nm, "_once"}, mb.out_valid, 0);
  endtask

  // ---------------- random sweep DUTs ----------------
  for (genvar g = 0; g < 8; g++) begin : sw
    localparam int W = (g < 2) ? 8 : (g < 4) ? 16 : (g < 6) ? 32 : 64;
    localparam int S = 2 + (g % 2);
    logic rs;
    bit   done = 1'b0;

    booth_mul_pipe_if #(.WIDTH(W), .TAG_W(4)) b ();
    booth_mul_pipe #(.WIDTH(W), .STAGES(S), .TAG_W(4)) dut (
      .mul_clk(clk), .reset(rs), .flush(1'b0), .bus(b)
    );

    function automatic logic [W-1:0] pick();
      logic [W-1:0] v;
      case ($urandom_range(0, 7))
        0:       v = '0;
        1:       v = '1;
        2:       begin v = '0; v[W-1] = 1'b1; end
        3:       begin v = '1; v[W-1] = 1'b0; end
        default: v = W'({$urandom(), $urandom()});
      endcase
      return v;
    endfunction

    initial begin : drv
      logic [2*W-1:0] eq [$];
      logic [3:0]     tq [$];
      logic [2*W-1:0] hres, e_res;
      logic [3:0]     htag, e_tag;
      int             acc;
      int             cyc;
      bit             held;
      string          nm;
      nm   = $sformatf("sw_w%0d_s%0d", W, S);
      acc  = 0;
      cyc  = 0;
      held = 1'b0;
      hres = '0;
      htag = '0;
      rs          = 1'b1;
      b.in_valid  = 1'b0;
      b.x         = '0;
      b.y         = '0;
      b.x_signed  = 1'b0;
      b.y_signed  = 1'b0;
      b.in_tag    = '0;
      b.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      rs = 1'b0;
      while ((acc < NOPS || eq.size() != 0) && cyc < 60000) begin
        @(negedge clk);
        cyc++;
        if (acc < NOPS) begin
          b.in_valid  = ($urandom_range(0, 3) != 0);
          b.x         = pick();
          b.y         = pick();
          b.x_signed  = 1'($urandom());
          b.y_signed  = 1'($urandom());
          b.in_tag    = 4'($urandom());
          b.out_ready = ($urandom_range(0, 3) != 0);
        end else begin
          b.in_valid  = 1'b0;
          b.out_ready = 1'b1;
        end
        #1;
        if (held) begin
          check({nm, "_hold"}, {b.out_valid, b.out_tag, b.result}, {1'b1, htag, hres});
        end
        if (b.out_valid && b.out_ready) begin
          if (eq.size() == 0) begin
            check({nm, "_extra"}, 1, 0);
          end else begin
            e_res = eq.pop_front();
            e_tag = tq.pop_front();
            check(nm, {b.out_tag, b.result}, {e_tag, e_res});
          end
        end
        if (b.in_valid && b.in_ready) begin
          acc++;
          eq.push_back((2*W)'(ref_any(W, 64'(b.x), 64'(b.y), b.x_signed, b.y_signed)));
          tq.push_back(b.in_tag);
        end
        held = b.out_valid && !b.out_ready;
        hres = b.result;
        htag = b.out_tag;
      end
      check({nm, "_accepted"}, acc, NOPS);
      check({nm, "_drained"}, eq.size(), 0);
      done = 1'b1;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    m_reset      = 1'b1;
    m_flush      = 1'b0;
    mb.out_ready = 1'b0;
    m_idle();

    vt[0]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 64'h0000000000000001};
    vt[1]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 64'hFFFFFFFE00000001};
    vt[2]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 64'hFFFFFFFF00000001};
    vt[3]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 64'hFFFFFFFF00000001};
    vt[4]  = '{32'h80000000, 32'h80000000, 1'b1, 1'b1, 64'h4000000000000000};
    vt[5]  = '{32'h80000000, 32'h00000002, 1'b0, 1'b0, 64'h0000000100000000};
    vt[6]  = '{32'h80000000, 32'h00000002, 1'b1, 1'b1, 64'hFFFFFFFF00000000};
    vt[7]  = '{32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b1, 64'hC000000080000000};
    vt[8]  = '{32'h00000000, 32'hDEADBEEF, 1'b1, 1'b1, 64'h0000000000000000};
    vt[9]  = '{32'h00000003, 32'h00000005, 1'b0, 1'b0, 64'h000000000000000F};
    vt[10] = '{32'hFFFFFFFD, 32'h00000005, 1'b1, 1'b1, 64'hFFFFFFFFFFFFFFF1};
    vt[11] = '{32'hFFFFFFFE, 32'h7FFFFFFF, 1'b1, 1'b1, 64'hFFFFFFFF00000002};

    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", mb.out_valid, 0);
    check("rst_result", mb.result, 0);
    check("rst_out_tag", mb.out_tag, 0);
    check("rst_in_ready", mb.in_ready, 0);
    m_reset = 1'b0;
    #1 check("rst_release_rdy", mb.in_ready, 1);

    for (int i = 0; i < 12; i++) begin
      single_op($sformatf("vec%0d", i), vt[i].x, vt[i].y, vt[i].xs, vt[i].ys, 4'(i), vt[i].exp);
    end

    // back-to-back
    @(negedge clk);
    mb.out_ready = 1'b1;
    m_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 4'd1);
    @(negedge clk);
    m_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 4'd2);
    @(negedge clk);
    m_idle();
    check("b2b_v0", mb.out_valid, 1);
    check("b2b_r0", mb.result, 64'h0000000000000001);
    check("b2b_t0", mb.out_tag, 1);
    @(negedge clk);
    check("b2b_v1", mb.out_valid, 1);
    check("b2b_r1", mb.result, 64'hFFFFFFFE00000001);
    check("b2b_t1", mb.out_tag, 2);
    @(negedge clk);
    check("b2b_end", mb.out_valid, 0);

    // back-pressure: 5 ops, consumer stalls for the first 4 cycles
    begin : bp
      logic [63:0] eq [$];
      logic [3:0]  tq [$];
      logic [63:0] hres, e_res;
      logic [3:0]  htag, e_tag;
      int          sent, got;
      bit          saw_low, held;
      sent = 0; got = 0; saw_low = 1'b0; held = 1'b0; hres = '0; htag = '0;
      for (int c = 0; c < 40 && got < 5; c++) begin
        @(negedge clk);
        mb.out_ready = (c >= 4);
        if (sent < 5) m_op($urandom(), $urandom(), sent[0], sent[1], 4'(sent + 8));
        else m_idle();
        #1;
        if (!mb.in_ready) saw_low = 1'b1;
        if (held) check("bp_hold", {mb.out_valid, mb.out_tag, mb.result}, {1'b1, htag, hres});
        if (mb.out_valid && mb.out_ready) begin
          got++;
          if (eq.size() == 0) begin
            check("bp_extra", 1, 0);
          end else begin
            e_res = eq.pop_front();
            e_tag = tq.pop_front();
            check("bp_result", {mb.out_tag, mb.result}, {e_tag, e_res});
          end
        end
        if (mb.in_valid && mb.in_ready) begin
          sent++;
          eq.push_back(64'(ref_any(32, 64'(mb.x), 64'(mb.y), mb.x_signed, mb.y_signed)));
          tq.push_back(mb.in_tag);
        end
        held = mb.out_valid && !mb.out_ready;
        hres = mb.result;
        htag = mb.out_tag;
      end
      check("bp_count", got, 5);
      check("bp_in_ready_dropped", saw_low, 1);
      m_idle();
      mb.out_ready = 1'b1;
    end

    // flush with two in flight and a third offered in the flush cycle
    @(negedge clk);
    mb.out_ready = 1'b0;
    m_op(32'd7, 32'd9, 1'b0, 1'b0, 4'd3);
    @(negedge clk);
    m_op(32'd11, 32'd13, 1'b0, 1'b0, 4'd4);
    @(negedge clk);
    m_op(32'd15, 32'd17, 1'b0, 1'b0, 4'd5);
    m_flush = 1'b1;
    #1 check("fl_in_ready", mb.in_ready, 0);
    @(negedge clk);
    m_flush = 1'b0;
    m_idle();
    mb.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("fl_quiet", mb.out_valid, 0);
      @(negedge clk);
    end
    single_op("fl_after", 32'h00010000, 32'h00010000, 1'b0, 1'b0, 4'd9, 64'h0000000100000000);

    // reset mid-stream
    @(negedge clk);
    mb.out_ready = 1'b0;
    m_op(32'd100, 32'd200, 1'b0, 1'b0, 4'd6);
    @(negedge clk);
    m_op(32'd300, 32'd400, 1'b0, 1'b0, 4'd7);
    @(negedge clk);
    m_idle();
    check("mr_pre_vld", mb.out_valid, 1);
    m_reset = 1'b1;
    #1 check("mr_in_ready", mb.in_ready, 0);
    @(negedge clk);
    check("mr_out_valid", mb.out_valid, 0);
    check("mr_result", mb.result, 0);
    check("mr_out_tag", mb.out_tag, 0);
    m_reset = 1'b0;
    mb.out_ready = 1'b1;
    #1 check("mr_release_rdy", mb.in_ready, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("mr_quiet", mb.out_valid, 0);
    end
    single_op("mr_after", 32'hFFFFFFFD, 32'h00000005, 1'b1, 1'b1, 4'd10, 64'hFFFFFFFFFFFFFFF1);

    begin : wait_sweeps
      int  cyc;
      bit  all_done;
      cyc = 0;
      all_done = 1'b0;
      while (!all_done && cyc < 70000) begin
        @(negedge clk);
        cyc++;
        all_done = sw[0].done && sw[1].done && sw[2].done && sw[3].done &&
                   sw[4].done && sw[5].done && sw[6].done && sw[7].done;
      end
      check("sweeps_finished", all_done, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
